// File: rtl/mmreq_bridge_pkg.sv
// Shared types for mmreq_bridge: FSM states, request header field positions,
// and the write-acknowledge response word layout.
package mmreq_bridge_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WR_BIT = 31;
  localparam int unsigned TAG_HI = 30;
  localparam int unsigned TAG_LO = 24;
  localparam int unsigned TAG_W  = TAG_HI - TAG_LO + 1;
  localparam int unsigned RSVD_W = WORD_W - 1 - TAG_W - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    BUS   = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic              wr;
    logic [TAG_W-1:0]  tag;
    logic [RSVD_W-1:0] rsvd;
    logic              timed_out;
  } wr_ack_t;

  function automatic logic [WORD_W-1:0] wr_ack_word(input logic [TAG_W-1:0] tag,
                                                    input logic timed_out);
    wr_ack_t w;
    w.wr        = 1'b1;
    w.tag       = tag;
    w.rsvd      = '0;
    w.timed_out = timed_out;
    return WORD_W'(w);
  endfunction

endpackage

// File: rtl/mmreq_bridge_watchdog.sv
// Bus-cycle watchdog: counts cycles spent in BUS, flags expiry, and keeps a
// saturating count of aborted bus cycles.
module mmreq_bridge_watchdog
  import mmreq_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             active,
  input  logic             ack,
  output logic             expire_c,
  output logic [CNT_W-1:0] timeout_count
);

  logic [CNT_W-1:0] cyc;

  // Holds at 1 outside BUS so the first BUS cycle is cycle 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc <= CNT_W'(1);
    end else if (active) begin
      cyc <= cyc + CNT_W'(1);
    end else begin
      cyc <= CNT_W'(1);
    end
  end

  assign expire_c = active && (cyc == CNT_W'(TIMEOUT_CYC));

  // An ack in the expiry cycle wins, so it is not counted as a timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_count <= '0;
    end else if (expire_c && !ack && (timeout_count != {CNT_W{1'b1}})) begin
      timeout_count <= timeout_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mmreq_bridge.sv
// Host memory-mapped request responder: pops request words, runs single-word
// register-bus cycles, pushes read data. MMREQ_BRIDGE_WRITE_ACK_EN adds write acks.
module mmreq_bridge
  import mmreq_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W      = 22,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_WORD    = 32'hBADA_CCE5
) (
  input  logic              bus_clk,
  input  logic              bus_rst,
  input  logic              req_open,
  input  logic [31:0]       req_dout,
  input  logic              req_empty,
  output logic              req_rden,
  output logic [31:0]       resp_din,
  output logic              resp_wren,
  input  logic              resp_full,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [31:0]       reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [31:0]       reg_rdata,
  input  logic              reg_ack,
  output logic [15:0]       timeout_count,
  output logic              busy
);

  state_t           state;
  logic             hdr_wr;
  logic [TAG_W-1:0] hdr_tag;
  logic             expire_c;
  logic             unused_c;

  mmreq_bridge_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk           (bus_clk),
    .rst           (bus_rst),
    .active        (state == BUS),
    .ack           (reg_ack),
    .expire_c      (expire_c),
    .timeout_count (timeout_count)
  );

  // FIFO handshakes must react to the flags in the same cycle (FWFT pop, full).
  assign req_rden  = !bus_rst && req_open && !req_empty &&
                     ((state == IDLE) || (state == WDATA));
  assign resp_wren = !bus_rst && (state == RESP) && !resp_full;
  assign busy      = (state != IDLE);

  assign unused_c = ^{req_dout, hdr_tag};

  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      state     <= IDLE;
      hdr_wr    <= 1'b0;
      hdr_tag   <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      resp_din  <= '0;
    end else begin
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;
      case (state)
        IDLE: begin
          if (req_open && !req_empty) begin
            hdr_wr   <= req_dout[WR_BIT];
            hdr_tag  <= req_dout[TAG_HI:TAG_LO];
            reg_addr <= req_dout[ADDR_W-1:0];
            if (req_dout[WR_BIT]) begin
              state <= WDATA;
            end else begin
              reg_rd <= 1'b1;
              state  <= BUS;
            end
          end
        end
        WDATA: begin
          if (!req_open) begin
            state <= IDLE;
          end else if (!req_empty) begin
            reg_wdata <= req_dout;
            reg_wr    <= 1'b1;
            state     <= BUS;
          end
        end
        BUS: begin
          if (reg_ack || expire_c) begin
            if (!hdr_wr) begin
              resp_din <= reg_ack ? reg_rdata : ERR_WORD;
              state    <= RESP;
            end else begin
`ifdef MMREQ_BRIDGE_WRITE_ACK_EN
              resp_din <= wr_ack_word(hdr_tag, !reg_ack);
              state    <= RESP;
`else
              state    <= IDLE;
`endif
            end
          end
        end
        RESP: begin
          if (!resp_full) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmreq_bridge.sv
// Self-checking bench for mmreq_bridge: FIFO and register-bus models, a vector
// table of single transactions, and hand-written multi-cycle sequences.
module tb_mmreq_bridge;

  localparam int unsigned ADDR_W  = 22;
  localparam int unsigned TO_CYC  = 8;
  localparam logic [31:0] ERR_W   = 32'hBADA_CCE5;
`ifdef MMREQ_BRIDGE_WRITE_ACK_EN
  localparam bit WACK = 1'b1;
`else
  localparam bit WACK = 1'b0;
`endif

  logic              bus_clk;
  logic              bus_rst;
  logic              req_open;
  logic [31:0]       req_dout;
  logic              req_empty;
  logic              req_rden;
  logic [31:0]       resp_din;
  logic              resp_wren;
  logic              resp_full;
  logic [ADDR_W-1:0] reg_addr;
  logic [31:0]       reg_wdata;
  logic              reg_wr;
  logic              reg_rd;
  logic [31:0]       reg_rdata;
  logic              reg_ack;
  logic [15:0]       timeout_count;
  logic              busy;

  logic        auto_ack;
  logic        force_ack;
  logic [31:0] rdata_val;

  assign reg_ack   = (auto_ack && (reg_rd || reg_wr)) || force_ack;
  assign reg_rdata = rdata_val;

  mmreq_bridge #(
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TO_CYC),
    .ERR_WORD    (ERR_W)
  ) dut (
    .bus_clk       (bus_clk),
    .bus_rst       (bus_rst),
    .req_open      (req_open),
    .req_dout      (req_dout),
    .req_empty     (req_empty),
    .req_rden      (req_rden),
    .resp_din      (resp_din),
    .resp_wren     (resp_wren),
    .resp_full     (resp_full),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_wr        (reg_wr),
    .reg_rd        (reg_rd),
    .reg_rdata     (reg_rdata),
    .reg_ack       (reg_ack),
    .timeout_count (timeout_count),
    .busy          (busy)
  );

  initial bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  typedef struct {
    logic [31:0] hdr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic [31:0] exp_addr;
    logic        exp_push;
    logic [31:0] exp_resp;
    int          exp_tc;
    int          lat;
  } vec_t;

  logic [31:0] reqq[$];
  logic [31:0] exp_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          n_pops = 0;
  int          n_push = 0;
  int          rd_cnt, wr_cnt, first_pop, ev_cyc;
  logic [31:0] bus_addr, bus_wdata;
  logic        pop_pend = 1'b0;
  int          tc_exp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic refresh();
    req_empty = (reqq.size() == 0);
    req_dout  = req_empty ? 32'h0 : reqq[0];
  endtask

  task automatic step();
    @(posedge bus_clk);
    #1;
    if (pop_pend) begin
      if (reqq.size() != 0) reqq.delete(0);
      pop_pend = 1'b0;
    end
    refresh();
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200; k++) begin
      if (reqq.size() == 0 && !busy) break;
      step();
    end
    chk("wait_idle", 32'(busy), 32'h0);
  endtask

  task automatic wait_pop();
    int p0;
    p0 = n_pops;
    for (int k = 0; k < 50; k++) begin
      step();
      if (n_pops != p0) break;
    end
    chk("pop_seen", 32'(n_pops - p0), 32'h1);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_req_rden"}, 32'(req_rden), 32'h0);
    chk({tag, "_resp_wren"}, 32'(resp_wren), 32'h0);
    chk({tag, "_reg_rd"}, 32'(reg_rd), 32'h0);
    chk({tag, "_reg_wr"}, 32'(reg_wr), 32'h0);
    chk({tag, "_reg_addr"}, 32'(reg_addr), 32'h0);
    chk({tag, "_reg_wdata"}, reg_wdata, 32'h0);
    chk({tag, "_resp_din"}, resp_din, 32'h0);
    chk({tag, "_timeout_count"}, 32'(timeout_count), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  // Bus and FIFO monitor, sampled mid-cycle.
  always @(negedge bus_clk) begin
    cyc++;
    if (!bus_rst) begin
      if (req_rden) begin
        chk("rden_while_empty", 32'(req_empty), 32'h0);
        pop_pend = 1'b1;
        n_pops++;
        if (first_pop < 0) first_pop = cyc;
      end
      if (reg_rd) begin
        rd_cnt++;
        bus_addr = 32'(reg_addr);
      end
      if (reg_wr) begin
        wr_cnt++;
        bus_addr  = 32'(reg_addr);
        bus_wdata = reg_wdata;
        if (ev_cyc < 0) ev_cyc = cyc;
      end
      if (resp_wren) begin
        n_push++;
        if (ev_cyc < 0) ev_cyc = cyc;
        chk("wren_while_full", 32'(resp_full), 32'h0);
        chk("push_expected", 32'(exp_q.size() != 0), 32'h1);
        if (exp_q.size() != 0) chk("resp_din", resp_din, exp_q.pop_front());
      end
    end
  end

  vec_t vecs[6];

  initial begin
    int p0, w0;

    vecs[0] = '{32'h0000_0010, 32'h0, 32'h1234_5678, 1'b1, 32'h10, 1'b1, 32'h1234_5678, 0, 2};
    vecs[1] = '{32'h8000_0004, 32'hCAFE_F00D, 32'h0, 1'b1, 32'h4, WACK, 32'h8000_0000, 0, 2};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0, 32'hA5A5_5A5A, 1'b1, 32'h3F_FFFF, 1'b1, 32'hA5A5_5A5A, 0, 2};
    vecs[3] = '{32'hD5C0_0123, 32'h0000_0001, 32'h0, 1'b1, 32'h123, WACK, 32'hD500_0000, 0, 2};
    vecs[4] = '{32'h0000_0020, 32'h0, 32'h0, 1'b0, 32'h20, 1'b1, ERR_W, 1, 9};
    vecs[5] = '{32'h8000_0008, 32'h0000_0001, 32'h0, 1'b0, 32'h8, WACK, 32'h8000_0001, 2, 2};

    bus_rst   = 1'b1;
    req_open  = 1'b0;
    resp_full = 1'b0;
    auto_ack  = 1'b0;
    force_ack = 1'b0;
    rdata_val = 32'h0;
    rd_cnt = 0; wr_cnt = 0; first_pop = -1; ev_cyc = -1;
    refresh();
    repeat (3) @(posedge bus_clk);
    #1;
    check_zero_outputs("reset");
    bus_rst  = 1'b0;
    req_open = 1'b1;

    for (int i = 0; i < 6; i++) begin
      auto_ack  = vecs[i].ack;
      rdata_val = vecs[i].rdata;
      rd_cnt = 0; wr_cnt = 0; first_pop = -1; ev_cyc = -1;
      bus_addr = 32'hFFFF_FFFF; bus_wdata = 32'hFFFF_FFFF;
      reqq.push_back(vecs[i].hdr);
      if (vecs[i].hdr[31]) reqq.push_back(vecs[i].wdata);
      if (vecs[i].exp_push) exp_q.push_back(vecs[i].exp_resp);
      refresh();
      wait_idle();
      chk($sformatf("v%0d_rd_cnt", i), 32'(rd_cnt), 32'(!vecs[i].hdr[31]));
      chk($sformatf("v%0d_wr_cnt", i), 32'(wr_cnt), 32'(vecs[i].hdr[31]));
      chk($sformatf("v%0d_addr", i), bus_addr, vecs[i].exp_addr);
      if (vecs[i].hdr[31]) chk($sformatf("v%0d_wdata", i), bus_wdata, vecs[i].wdata);
      chk($sformatf("v%0d_timeout_count", i), 32'(timeout_count), 32'(vecs[i].exp_tc));
      chk($sformatf("v%0d_latency", i), 32'(ev_cyc - first_pop), 32'(vecs[i].lat));
      chk($sformatf("v%0d_resp_drained", i), 32'(exp_q.size()), 32'h0);
    end
    tc_exp = 2;

    // Channel closed while idle: header stays in the FIFO.
    p0 = n_pops;
    req_open = 1'b0;
    reqq.push_back(32'h0000_0070);
    refresh();
    repeat (5) step();
    chk("closed_no_pop", 32'(n_pops - p0), 32'h0);
    chk("closed_idle", 32'(busy), 32'h0);
    reqq.delete();
    refresh();
    req_open = 1'b1;

    // Timeout followed by a late ack, which must be ignored.
    auto_ack = 1'b0;
    reqq.push_back(32'h0000_0030);
    exp_q.push_back(ERR_W);
    tc_exp++;
    refresh();
    wait_idle();
    w0 = n_push;
    repeat (2) step();
    rdata_val = 32'h1111_2222;
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    repeat (3) step();
    chk("late_ack_idle", 32'(busy), 32'h0);
    chk("late_ack_no_push", 32'(n_push - w0), 32'h0);
    chk("late_ack_timeout_count", 32'(timeout_count), 32'(tc_exp));

    // Response backpressure with a second request queued behind.
    auto_ack  = 1'b1;
    rdata_val = 32'h5555_AAAA;
    resp_full = 1'b1;
    p0 = n_pops;
    w0 = n_push;
    reqq.push_back(32'h0000_0040);
    reqq.push_back(32'h0000_0044);
    exp_q.push_back(32'h5555_AAAA);
    exp_q.push_back(32'h5555_AAAA);
    refresh();
    repeat (22) step();
    chk("bp_pops_held", 32'(n_pops - p0), 32'h1);
    chk("bp_no_push", 32'(n_push - w0), 32'h0);
    chk("bp_busy", 32'(busy), 32'h1);
    resp_full = 1'b0;
    step();
    chk("bp_one_push", 32'(n_push - w0), 32'h1);
    wait_idle();
    chk("bp_pops_total", 32'(n_pops - p0), 32'h2);
    chk("bp_push_total", 32'(n_push - w0), 32'h2);
    chk("bp_drained", 32'(exp_q.size()), 32'h0);

    // Channel closes between write header and data word.
    rd_cnt = 0; wr_cnt = 0;
    p0 = n_pops;
    reqq.push_back(32'h8000_0050);
    refresh();
    wait_pop();
    req_open = 1'b0;
    reqq.push_back(32'hDEAD_BEEF);
    refresh();
    repeat (6) step();
    chk("close_idle", 32'(busy), 32'h0);
    chk("close_no_wr", 32'(wr_cnt), 32'h0);
    chk("close_pops", 32'(n_pops - p0), 32'h1);
    chk("close_data_left", 32'(reqq.size()), 32'h1);
    reqq.delete();
    refresh();
    req_open = 1'b1;

    // Reset while a read waits in BUS.
    auto_ack = 1'b0;
    w0 = n_push;
    reqq.push_back(32'h0000_0060);
    refresh();
    wait_pop();
    chk("rst_strobe_live", 32'(reg_rd), 32'h1);
    bus_rst = 1'b1;
    step();
    check_zero_outputs("rst_bus");
    bus_rst = 1'b0;
    tc_exp = 0;
    repeat (15) step();
    chk("rst_no_push", 32'(n_push - w0), 32'h0);
    chk("rst_idle", 32'(busy), 32'h0);
    chk("rst_timeout_count", 32'(timeout_count), 32'(tc_exp));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
